// File: rtl/tone_scheduler_if.sv
// tone_scheduler_if: request/cancel inputs and tone status outputs of the shared tone scheduler.
interface tone_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 26
);
    logic [NREQ-1:0]         req;
    logic                    cancel;
    logic                    tone_active;
    logic [$clog2(NREQ)-1:0] tone_sel;
    logic [NREQ-1:0]         tone_done;
    logic [NREQ-1:0]         pending;
    logic [CNT_W-1:0]        count;
    modport master (output req, cancel, input tone_active, tone_sel, tone_done, pending, count);
    modport slave  (input req, cancel, output tone_active, tone_sel, tone_done, pending, count);
endinterface

// File: rtl/tone_scheduler.sv
// tone_scheduler: round-robin sharing of one fixed-length tone generator among NREQ switch requesters.
// Define TONE_GAP_EN to insert GAP_CYCLES of silence after every completed tone.
module tone_scheduler #(
    parameter int NREQ        = 4,
    parameter int TONE_CYCLES = 50000000,
    parameter int GAP_CYCLES  = 5000000,
    parameter int CNT_W       = 26
) (
    input  logic             Clk,
    input  logic             Reset_n,
    tone_scheduler_if.slave  bus
);
    localparam int SEL_W = $clog2(NREQ);
    localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_CYCLES - 1);
`ifdef TONE_GAP_EN
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
`else
    typedef enum logic {IDLE, PLAY} state_t;
`endif

    if (NREQ < 2 || NREQ > 8 || TONE_CYCLES < 2 || GAP_CYCLES < 1 ||
        ((TONE_CYCLES - 1) >> CNT_W) != 0 || ((GAP_CYCLES - 1) >> CNT_W) != 0) begin : g_bad_cfg
        $error("tone_scheduler: illegal parameter combination");
    end

    state_t            state_q, state_d;
    logic [NREQ-1:0]   s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [1:0]        arm_q, arm_d;
    logic [NREQ-1:0]   pend_q, pend_d, done_q, done_d;
    logic [SEL_W-1:0]  sel_q, sel_d, ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NREQ-1:0]   rise, grant;
    logic [SEL_W-1:0]  win;
    logic              found;
    int                idx;

    // Edges are ignored until the sync chain has flushed, so a level held through reset never queues.
    always_comb begin
        s1_d  = bus.req;
        s2_d  = s1_q;
        s3_d  = s2_q;
        arm_d = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
        rise  = s2_q & ~s3_q & {NREQ{arm_q == 2'd3}};
    end

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && pend_q[idx]) begin
                found = 1'b1;
                win   = SEL_W'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        done_d  = '0;
        grant   = '0;
        case (state_q)
            IDLE: if (|pend_q) begin
                grant[win] = 1'b1;
                sel_d      = win;
                ptr_d      = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
                cnt_d      = '0;
                state_d    = PLAY;
            end
            PLAY: if (bus.cancel) begin
                cnt_d   = '0;
                state_d = IDLE;
            end else if (cnt_q == TONE_LAST) begin
                done_d[sel_q] = 1'b1;
                cnt_d         = '0;
`ifdef TONE_GAP_EN
                state_d       = GAP;
`else
                state_d       = IDLE;
`endif
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
`ifdef TONE_GAP_EN
            GAP: begin
                cnt_d   = (cnt_q == GAP_LAST) ? '0 : cnt_q + 1'b1;
                state_d = (cnt_q == GAP_LAST) ? IDLE : GAP;
            end
`endif
            default: state_d = IDLE;
        endcase
        pend_d = (pend_q & ~grant) | rise;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            arm_q   <= '0;
            pend_q  <= '0;
            done_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            arm_q   <= arm_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.tone_active = (state_q == PLAY);
    assign bus.tone_sel    = sel_q;
    assign bus.tone_done   = done_q;
    assign bus.pending     = pend_q;
    assign bus.count       = cnt_q;
endmodule

// File: doc/tone_scheduler.md
Name: tone_scheduler

Overview:
Shares one tone generator among NREQ switch requesters. Each rising edge on a request input queues one fixed-length tone for that requester. A round-robin arbiter picks the next pending requester, drives tone_sel/tone_active for exactly TONE_CYCLES clocks, then pulses that requester's tone_done. Sits between the board switch inputs and the audio tone datapath, and replaces per-switch one-second timers.

Parameters:
NREQ, 4, number of requesters (2..8)
TONE_CYCLES, 50000000, tone length in Clk cycles (1 s at 50 MHz); must be >= 2
GAP_CYCLES, 5000000, silence between consecutive tones (used only with TONE_GAP_EN); must be >= 1
CNT_W, 26, counter width; must hold max(TONE_CYCLES, GAP_CYCLES)-1

Ports:
Clk  input  1  system clock
Reset_n  input  1  asynchronous, active-low reset
req  input  NREQ  level request switches, asynchronous to Clk
cancel  input  1  synchronous abort of the tone now playing
tone_active  output  1  high while the tone datapath must sound
tone_sel  output  $clog2(NREQ)  index of the requester being served; valid while tone_active
tone_done  output  NREQ  one-cycle completion pulse, one bit per requester
pending  output  NREQ  queued-request flags
count  output  CNT_W  current PLAY/GAP cycle counter

Behaviour:
- Reset (Reset_n low, asynchronous): all flops clear. tone_active=0, tone_sel=0, tone_done=0, pending=0, count=0, rr pointer=0, synchronizers=0, state=IDLE.
- Input conditioning: each req bit passes through a 2-flop synchronizer, then a rising-edge detect. pending[i] sets 3 cycles after req[i] is first sampled high. A held-high level queues once. A req level already high at reset release does not queue.
- pending[i] is set by an edge and cleared when requester i is granted. If an edge and a grant of the same bit occur in the same cycle, the edge wins and pending stays 1, so the request is re-queued.
- Arbiter: round-robin starting at index (last_granted+1) mod NREQ. After reset the search starts at index 0.
- FSM states:
  - IDLE: if pending != 0, grant the winner on the next edge: tone_sel=winner, pending[winner] clears, count=0, go to PLAY.
  - PLAY: tone_active=1 and count increments each cycle.
    - At count==TONE_CYCLES-1: tone_done[tone_sel] pulses for the next cycle only, count=0, tone_active=0, go to GAP if enabled, otherwise IDLE.
    - tone_active is high for exactly TONE_CYCLES cycles.
  - GAP (TONE_GAP_EN only): tone_active=0 and count increments. At count==GAP_CYCLES-1, count=0 and go to IDLE.
- Back-to-back service: IDLE with pending set grants in 1 cycle. Without the gap, there is exactly one idle cycle between tones.
- cancel:
  - In PLAY: on the next edge tone_active=0, count=0, no tone_done pulse, state=IDLE (GAP is skipped). The rr pointer still advances past the cancelled index.
  - In IDLE or GAP: ignored; pending is untouched.
- count wraps only via the explicit compare, never by overflow. tone_sel holds its last value when idle.
- Reset mid-tone: tone aborts immediately, no done pulse, and all queued requests are lost.

Optional Feature:
TONE_GAP_EN
- Defined: GAP state is compiled in; GAP_CYCLES of silence are inserted after every completed (not cancelled) tone.
- Undefined: GAP state and logic are absent, GAP_CYCLES is unused, and PLAY goes directly to IDLE.

Test Plan:
Use NREQ=4, TONE_CYCLES=8, GAP_CYCLES=3.
- Reset: hold Reset_n=0 for 3 cycles with req=4'b1111 -> all outputs 0. After release with req still 4'b1111, no pending bits set.
- Single request: pulse req[2] high for 5 cycles -> pending=4'b0100 at cycle +3. Next cycle tone_active=1 and tone_sel=2 for exactly 8 cycles. tone_done=4'b0100 for 1 cycle. pending=0.
- Round-robin: raise req[0], req[1] and req[3] together -> service order 0,1,3. Three done pulses. With TONE_GAP_EN, tone_active is low 4 cycles between tones (3 gap + 1 idle); without it, low 1 cycle.
- Cancel: start a tone for req[1] and assert cancel at count=4 -> tone_active=0 the next cycle, no tone_done, state IDLE. A pending req[2] is granted the following cycle.
- Re-queue: produce a new req[1] edge that reaches pending in the grant cycle of requester 1 -> pending[1] stays 1, and requester 1 is served twice in total.
- Async reset mid-tone: drop Reset_n at count=5 -> tone_active drops in the same cycle without waiting for Clk, and no done pulse follows.
